h264_mb_sequencer: RTL and testbench
====================================

# h264_mb_sequencer

Per-frame macroblock sequencer for the encoder back end. It drives the coefficient reorder buffer's `NEWSLICE` and `NEWLINE` controls, and orders slice-header and MB-header emission against residual output so header bits never interleave with a macroblock's coefficients. It also starts the transform path feeding each macroblock into the buffer, and tracks macroblock X/Y position through the frame.

## Interface
Parameters:
- `MB_WIDTH`, default 11: macroblocks per line, 1..255.
- `MB_HEIGHT`, default 9: macroblock lines per frame, 1..255.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `RSTN`  in  1  asynchronous, active-low reset.
- `START`  in  1  frame start request; sampled only in IDLE.
- `INTER`  in  1  frame coding mode (1 = inter); latched on an accepted `START`.
- `INTER_FLAG`  out  1  latched mode, fed to the buffer's `inter_flag`.
- `NEWSLICE`  out  1  buffer slice reset.
- `NEWLINE`  out  1  buffer new-line strobe.
- `BUF_DONE`  in  1  buffer `DONE` (buffer quiescent and empty).
- `BUF_FULL`  in  1  buffer `buffer_FULL` pulse (one whole MB written).
- `HDR_START`  out  1  one-cycle header request.
- `HDR_SLICE`  out  1  qualifies `HDR_START`: 1 = slice header, 0 = MB header.
- `HDR_DONE`  in  1  header module finished, one-cycle pulse.
- `XFORM_READY`  in  1  transform path can accept a new MB.
- `XFORM_GO`  out  1  one-cycle start of MB feed into the buffer.
- `MBX`  out  8  current MB column.
- `MBY`  out  8  current MB row.
- `BUSY`  out  1  high in every state except IDLE.
- `FRAME_DONE`  out  1  one-cycle pulse when the last MB has drained.
- `ERR`  out  1  sticky protocol error; cleared on an accepted `START`.

## Operation
- **States:** IDLE, SLICE, WAIT_SHDR, WAIT_DRAIN, MB_HDR, WAIT_MHDR, FEED, WAIT_FULL, ADVANCE, FLUSH, FIN.
- **IDLE:**
  - `NEWSLICE`=1, which holds the buffer in reset.
  - On `START`=1: latch `INTER` into `INTER_FLAG`, clear `MBX`, `MBY` and `ERR`, then go to SLICE.
- **SLICE (1 cycle):** `NEWSLICE`=1, `HDR_START`=1, `HDR_SLICE`=1. Then go to WAIT_SHDR.
- **WAIT_SHDR:** on `HDR_DONE`, go to WAIT_DRAIN.
- **WAIT_DRAIN:** wait for `BUF_DONE`=1 (previous MB fully output), then go to MB_HDR.
- **MB_HDR (1 cycle):** `HDR_START`=1, `HDR_SLICE`=0. Then go to WAIT_MHDR.
- **WAIT_MHDR:** on `HDR_DONE`, go to FEED.
- **FEED:** when `XFORM_READY`=1, assert `XFORM_GO` for that cycle and go to WAIT_FULL.
- **WAIT_FULL:** on `BUF_FULL`, go to ADVANCE.
- **ADVANCE (1 cycle):**
  - If `MBX`=`MB_WIDTH`-1 and `MBY`=`MB_HEIGHT`-1: go to FLUSH.
  - Else if `MBX`=`MB_WIDTH`-1: `MBX`←0, `MBY`←`MBY`+1, `NEWLINE`=1 in the next cycle (first cycle of WAIT_DRAIN); go to WAIT_DRAIN.
  - Else: `MBX`←`MBX`+1; go to WAIT_DRAIN.
- **FLUSH:** wait for `BUF_DONE`=1, then go to FIN.
- **FIN (1 cycle):** `FRAME_DONE`=1. Then go to IDLE.
- **ERR set (sticky):**
  - `HDR_DONE` arriving outside WAIT_SHDR or WAIT_MHDR.
  - `BUF_FULL` arriving outside WAIT_FULL.
  - The offending pulse is otherwise ignored and the state is unchanged.
- **Mode and position:**
  - `START` while `BUSY` is ignored.
  - `INTER_FLAG` is constant for the whole frame.
  - `MBX` and `MBY` stay at the last MB's value after FIN, until the next `START`.
- **Dimension rules:**
  - `MB_WIDTH`=1: every ADVANCE that is not last wraps and pulses `NEWLINE`.
  - `MB_HEIGHT`=1: `NEWLINE` never fires.

## Timing
- **Reset values:**
  - State IDLE, `NEWSLICE`=1.
  - All other outputs 0: `NEWLINE`, `HDR_START`, `HDR_SLICE`, `XFORM_GO`, `MBX`, `MBY`, `BUSY`, `FRAME_DONE`, `ERR`, `INTER_FLAG`.
- **Outputs:** all registered; they change only on `CLK` rising edges, apart from the asynchronous reset.
- **Reset mid-frame:** `RSTN` low forces the reset values immediately, and `NEWSLICE`=1 resets the buffer.
- **Start latency:**
  - `START` at edge N gives `HDR_START`/`HDR_SLICE` high in cycle N+1.
  - `NEWSLICE` falls at N+2.
- **Slice header to first MB header:** `HDR_DONE` at cycle M gives the first MB-header `HDR_START` no earlier than M+2, since WAIT_DRAIN needs `BUF_DONE` for at least 1 cycle.
- **MB header to feed:** `HDR_DONE` at K gives `XFORM_GO` at K+1 if `XFORM_READY` is already high.
- **Per-MB overhead:**
  - 1 cycle in ADVANCE.
  - 1 cycle in MB_HDR.
  - The handshake waits.
- **Simultaneous events:** `BUF_FULL` and a stray `HDR_DONE` in the same WAIT_FULL cycle advance the state and set `ERR`.

## Test plan
- **Reset:** `RSTN` low, then release with `START`=0 → `NEWSLICE`=1, `BUSY`=0, all other outputs 0. Hold 20 cycles unchanged.
- **Frame 2×2, INTER=1, ideal responders:**
  - `HDR_START` occurs 5 times, with `HDR_SLICE` sequence 1,0,0,0,0.
  - `XFORM_GO` occurs 4 times; (`MBX`,`MBY`) = (0,0),(1,0),(0,1),(1,1).
  - Exactly one `NEWLINE`, between MB 2 and MB 3.
  - `FRAME_DONE` occurs once; `INTER_FLAG`=1 throughout.
- **Backpressure:**
  - Hold `BUF_DONE`=0 for 50 cycles in WAIT_DRAIN → no `HDR_START`.
  - Hold `XFORM_READY`=0 for 30 cycles in FEED → no `XFORM_GO`.
  - On release, the first event follows on the next cycle.
- **Protocol errors:**
  - `BUF_FULL` pulse during WAIT_MHDR → `ERR`=1, state unchanged.
  - `ERR` stays 1 through FIN; the next `START` clears it.
- **`MB_WIDTH`=1, `MB_HEIGHT`=3:**
  - `NEWLINE` twice; `MBY` goes 0→1→2; `MBX` stays 0.
  - `START` pulses while `BUSY` are ignored; one `FRAME_DONE`.
- **Reset mid-frame:**
  - Assert `RSTN` low during WAIT_FULL of MB 1 → immediate IDLE, `NEWSLICE`=1.
  - A new `START` replays the frame from (0,0).

Source files
------------

// File: rtl/h264_mb_sequencer.sv
// Per-frame macroblock sequencer: orders slice/MB header emission against residual output,
// starts the transform feed for each MB and tracks the MB position through the frame.
module h264_mb_sequencer #(
    parameter int unsigned MB_WIDTH  = 11,
    parameter int unsigned MB_HEIGHT = 9
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       INTER,
    output logic       INTER_FLAG,
    output logic       NEWSLICE,
    output logic       NEWLINE,
    input  logic       BUF_DONE,
    input  logic       BUF_FULL,
    output logic       HDR_START,
    output logic       HDR_SLICE,
    input  logic       HDR_DONE,
    input  logic       XFORM_READY,
    output logic       XFORM_GO,
    output logic [7:0] MBX,
    output logic [7:0] MBY,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       ERR
);

    localparam logic [7:0] LastX = 8'(MB_WIDTH - 1);
    localparam logic [7:0] LastY = 8'(MB_HEIGHT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StSlice,
        StWaitShdr,
        StWaitDrain,
        StMbHdr,
        StWaitMhdr,
        StFeed,
        StWaitFull,
        StAdvance,
        StFlush,
        StFin
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] mbx_q, mbx_d;
    logic [7:0] mby_q, mby_d;
    logic       inter_q, inter_d;
    logic       err_q, err_d;
    logic       newline_q, newline_d;
    logic       go_q, go_d;
    logic       newslice_q, hdr_start_q, hdr_slice_q, busy_q, frame_done_q;
    logic       at_last_x, at_last_y, hdr_expected, full_expected;

    always_comb begin
        at_last_x     = (mbx_q == LastX);
        at_last_y     = (mby_q == LastY);
        hdr_expected  = (state_q == StWaitShdr) || (state_q == StWaitMhdr);
        full_expected = (state_q == StWaitFull);
    end

    always_comb begin
        state_d   = state_q;
        mbx_d     = mbx_q;
        mby_d     = mby_q;
        inter_d   = inter_q;
        err_d     = err_q;
        newline_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    inter_d = INTER;
                    mbx_d   = 8'd0;
                    mby_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = StSlice;
                end
            end
            StSlice:     state_d = StWaitShdr;
            StWaitShdr:  if (HDR_DONE) state_d = StWaitDrain;
            StWaitDrain: if (BUF_DONE) state_d = StMbHdr;
            StMbHdr:     state_d = StWaitMhdr;
            StWaitMhdr:  if (HDR_DONE) state_d = StFeed;
            // go_q marks the cycle the feed start is actually presented downstream
            StFeed:      if (go_q) state_d = StWaitFull;
            StWaitFull:  if (BUF_FULL) state_d = StAdvance;
            StAdvance: begin
                if (at_last_x && at_last_y) begin
                    state_d = StFlush;
                end else if (at_last_x) begin
                    mbx_d     = 8'd0;
                    mby_d     = mby_q + 8'd1;
                    newline_d = 1'b1;
                    state_d   = StWaitDrain;
                end else begin
                    mbx_d   = mbx_q + 8'd1;
                    state_d = StWaitDrain;
                end
            end
            StFlush:     if (BUF_DONE) state_d = StFin;
            StFin:       state_d = StIdle;
            default:     state_d = StIdle;
        endcase

        // Stray handshake pulses never move the FSM; they only flag the error.
        if ((HDR_DONE && !hdr_expected) || (BUF_FULL && !full_expected)) begin
            err_d = 1'b1;
        end

        // Issue the feed start in the first FEED cycle the transform path is ready.
        go_d = (state_d == StFeed) && XFORM_READY;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= StIdle;
            mbx_q        <= 8'd0;
            mby_q        <= 8'd0;
            inter_q      <= 1'b0;
            err_q        <= 1'b0;
            newline_q    <= 1'b0;
            go_q         <= 1'b0;
            newslice_q   <= 1'b1;
            hdr_start_q  <= 1'b0;
            hdr_slice_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mbx_q        <= mbx_d;
            mby_q        <= mby_d;
            inter_q      <= inter_d;
            err_q        <= err_d;
            newline_q    <= newline_d;
            go_q         <= go_d;
            newslice_q   <= (state_d == StIdle) || (state_d == StSlice);
            hdr_start_q  <= (state_d == StSlice) || (state_d == StMbHdr);
            hdr_slice_q  <= (state_d == StSlice);
            busy_q       <= (state_d != StIdle);
            frame_done_q <= (state_d == StFin);
        end
    end

    assign INTER_FLAG = inter_q;
    assign NEWSLICE   = newslice_q;
    assign NEWLINE    = newline_q;
    assign HDR_START  = hdr_start_q;
    assign HDR_SLICE  = hdr_slice_q;
    assign XFORM_GO   = go_q;
    assign MBX        = mbx_q;
    assign MBY        = mby_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_h264_mb_sequencer.sv
// Directed bench: instance 0 is a 2x2 frame, instance 1 a 1x3 frame; the bench plays the
// header module, buffer and transform path by hand.
module tb_h264_mb_sequencer;

    localparam logic [24:0] RstVec = 25'h0800000;
    localparam int HS = 0;
    localparam int GO = 1;
    localparam int FD = 2;

    logic        clk;
    logic        rstn;
    logic [1:0]  start, inter, buf_done, buf_full, hdr_done, xform_ready;
    logic [1:0]  inter_flag, newslice, newline, hdr_start, hdr_slice, xform_go;
    logic [1:0]  busy, frame_done, err;
    logic [15:0] mbx_v, mby_v;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int hs_cnt[2];
    int go_cnt[2];
    int nl_cnt[2];
    int fd_cnt[2];
    int base_hs, base_go, base_nl, base_fd;
    logic [1:0] exp_inter;

    h264_mb_sequencer #(.MB_WIDTH(2), .MB_HEIGHT(2)) u_dut0 (
        .CLK(clk), .RSTN(rstn), .START(start[0]), .INTER(inter[0]),
        .INTER_FLAG(inter_flag[0]), .NEWSLICE(newslice[0]), .NEWLINE(newline[0]),
        .BUF_DONE(buf_done[0]), .BUF_FULL(buf_full[0]),
        .HDR_START(hdr_start[0]), .HDR_SLICE(hdr_slice[0]), .HDR_DONE(hdr_done[0]),
        .XFORM_READY(xform_ready[0]), .XFORM_GO(xform_go[0]),
        .MBX(mbx_v[7:0]), .MBY(mby_v[7:0]),
        .BUSY(busy[0]), .FRAME_DONE(frame_done[0]), .ERR(err[0])
    );

    h264_mb_sequencer #(.MB_WIDTH(1), .MB_HEIGHT(3)) u_dut1 (
        .CLK(clk), .RSTN(rstn), .START(start[1]), .INTER(inter[1]),
        .INTER_FLAG(inter_flag[1]), .NEWSLICE(newslice[1]), .NEWLINE(newline[1]),
        .BUF_DONE(buf_done[1]), .BUF_FULL(buf_full[1]),
        .HDR_START(hdr_start[1]), .HDR_SLICE(hdr_slice[1]), .HDR_DONE(hdr_done[1]),
        .XFORM_READY(xform_ready[1]), .XFORM_GO(xform_go[1]),
        .MBX(mbx_v[15:8]), .MBY(mby_v[15:8]),
        .BUSY(busy[1]), .FRAME_DONE(frame_done[1]), .ERR(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (hdr_start[i])  hs_cnt[i]++;
            if (xform_go[i])   go_cnt[i]++;
            if (newline[i])    nl_cnt[i]++;
            if (frame_done[i]) fd_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (failure #%0d)", tag, obs, exp, n_fail);
        end
    endtask

    function automatic logic [24:0] outs(input int idx);
        return {inter_flag[idx], newslice[idx], newline[idx], hdr_start[idx], hdr_slice[idx],
                xform_go[idx], busy[idx], frame_done[idx], err[idx],
                mbx_v[idx*8 +: 8], mby_v[idx*8 +: 8]};
    endfunction

    function automatic logic out_bit(input int idx, input int which);
        case (which)
            HS:      return hdr_start[idx];
            GO:      return xform_go[idx];
            default: return frame_done[idx];
        endcase
    endfunction

    task automatic wait_out(input int idx, input int which, input int bound, input string tag);
        int n = 0;
        while (!out_bit(idx, which) && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(out_bit(idx, which)), 1);
    endtask

    task automatic frame_start(input int idx, input logic mode);
        inter[idx]     = mode;
        exp_inter[idx] = mode;
        start[idx]     = 1'b1;
        tick();
        start[idx]     = 1'b0;
    endtask

    task automatic hdr_reply(input int idx);
        tick();
        hdr_done[idx] = 1'b1;
        tick();
        hdr_done[idx] = 1'b0;
    endtask

    task automatic slice_hdr(input int idx);
        wait_out(idx, HS, 20, "slice_hdr_start");
        check("slice_hdr_slice", 32'(hdr_slice[idx]), 1);
        hdr_reply(idx);
        check("mb_hdr_not_before_m2", 32'(hdr_start[idx]), 0);
    endtask

    task automatic feed_after_go(input int idx, input logic exp_nl);
        buf_done[idx] = 1'b0;
        tick();
        check("go_one_cycle", 32'(xform_go[idx]), 0);
        tick();
        buf_full[idx] = 1'b1;
        tick();
        buf_full[idx] = 1'b0;
        tick();
        check("newline", 32'(newline[idx]), 32'(exp_nl));
        buf_done[idx] = 1'b1;
    endtask

    task automatic mb(input int idx, input int x, input int y, input logic exp_nl);
        wait_out(idx, HS, 20, "mb_hdr_start");
        check("mb_hdr_slice", 32'(hdr_slice[idx]), 0);
        hdr_reply(idx);
        check("go_latency", 32'(xform_go[idx]), 1);
        check("mbx_at_go", 32'(mbx_v[idx*8 +: 8]), 32'(x));
        check("mby_at_go", 32'(mby_v[idx*8 +: 8]), 32'(y));
        check("inter_flag", 32'(inter_flag[idx]), 32'(exp_inter[idx]));
        feed_after_go(idx, exp_nl);
    endtask

    task automatic snap(input int idx);
        base_hs = hs_cnt[idx];
        base_go = go_cnt[idx];
        base_nl = nl_cnt[idx];
        base_fd = fd_cnt[idx];
    endtask

    initial begin
        rstn        = 1'b1;
        start       = 2'b00;
        inter       = 2'b00;
        buf_done    = 2'b11;
        buf_full    = 2'b00;
        hdr_done    = 2'b00;
        xform_ready = 2'b11;
        exp_inter   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            hs_cnt[i] = 0; go_cnt[i] = 0; nl_cnt[i] = 0; fd_cnt[i] = 0;
        end
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vec0", 32'(outs(0)), 32'(RstVec));
        check("reset_vec1", 32'(outs(1)), 32'(RstVec));
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_hold", 32'(outs(0)), 32'(RstVec));
        end

        // Frame A: 2x2 inter frame with prompt responders.
        snap(0);
        frame_start(0, 1'b1);
        slice_hdr(0);
        mb(0, 0, 0, 1'b0);
        mb(0, 1, 0, 1'b1);
        mb(0, 0, 1, 1'b0);
        mb(0, 1, 1, 1'b0);
        wait_out(0, FD, 20, "frame_done_a");
        tick();
        check("a_hdr_count", 32'(hs_cnt[0] - base_hs), 5);
        check("a_go_count", 32'(go_cnt[0] - base_go), 4);
        check("a_newline_count", 32'(nl_cnt[0] - base_nl), 1);
        check("a_done_count", 32'(fd_cnt[0] - base_fd), 1);
        check("a_idle_vec", 32'(outs(0)), 32'(25'h1800101));

        // Frame B: start latency, drain/ready backpressure and a stray BUF_FULL.
        buf_done[0] = 1'b0;
        frame_start(0, 1'b0);
        check("b_start_hdr", 32'(hdr_start[0]), 1);
        check("b_start_slice", 32'(hdr_slice[0]), 1);
        check("b_newslice_n1", 32'(newslice[0]), 1);
        tick();
        check("b_newslice_n2", 32'(newslice[0]), 0);
        check("b_inter_flag", 32'(inter_flag[0]), 0);
        hdr_done[0] = 1'b1;
        tick();
        hdr_done[0] = 1'b0;
        snap(0);
        repeat (50) tick();
        check("b_drain_hold", 32'(hs_cnt[0] - base_hs), 0);
        buf_done[0] = 1'b1;
        tick();
        check("b_drain_release", 32'(hdr_start[0]), 1);
        xform_ready[0] = 1'b0;
        tick();
        buf_full[0] = 1'b1;
        tick();
        buf_full[0] = 1'b0;
        check("b_err_set", 32'(err[0]), 1);
        check("b_busy", 32'(busy[0]), 1);
        hdr_done[0] = 1'b1;
        tick();
        hdr_done[0] = 1'b0;
        snap(0);
        repeat (30) tick();
        check("b_ready_hold", 32'(go_cnt[0] - base_go), 0);
        xform_ready[0] = 1'b1;
        tick();
        check("b_ready_release", 32'(xform_go[0]), 1);
        check("b_mbx0", 32'(mbx_v[7:0]), 0);
        feed_after_go(0, 1'b0);
        mb(0, 1, 0, 1'b1);
        mb(0, 0, 1, 1'b0);
        mb(0, 1, 1, 1'b0);
        wait_out(0, FD, 20, "frame_done_b");
        check("b_err_at_fin", 32'(err[0]), 1);
        tick();
        check("b_err_idle", 32'(err[0]), 1);

        // Frame C: reset during WAIT_FULL of MB 1.
        frame_start(0, 1'b1);
        check("c_err_cleared", 32'(err[0]), 0);
        slice_hdr(0);
        mb(0, 0, 0, 1'b0);
        wait_out(0, HS, 20, "c_mb1_hdr");
        hdr_reply(0);
        check("c_go_mb1", 32'(xform_go[0]), 1);
        check("c_mbx_mb1", 32'(mbx_v[7:0]), 1);
        tick();
        #2 rstn = 1'b0;
        #1;
        check("c_async_reset", 32'(outs(0)), 32'(RstVec));
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Frame D: replay from (0,0) after the mid-frame reset.
        snap(0);
        frame_start(0, 1'b1);
        slice_hdr(0);
        mb(0, 0, 0, 1'b0);
        mb(0, 1, 0, 1'b1);
        mb(0, 0, 1, 1'b0);
        mb(0, 1, 1, 1'b0);
        wait_out(0, FD, 20, "frame_done_d");
        tick();
        check("d_hdr_count", 32'(hs_cnt[0] - base_hs), 5);
        check("d_newline_count", 32'(nl_cnt[0] - base_nl), 1);
        check("d_done_count", 32'(fd_cnt[0] - base_fd), 1);

        // Instance 1: one MB per line, three lines, START pulses while busy.
        snap(1);
        frame_start(1, 1'b0);
        slice_hdr(1);
        mb(1, 0, 0, 1'b1);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        mb(1, 0, 1, 1'b1);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        mb(1, 0, 2, 1'b0);
        wait_out(1, FD, 20, "frame_done_e");
        repeat (6) tick();
        check("e_hdr_count", 32'(hs_cnt[1] - base_hs), 4);
        check("e_newline_count", 32'(nl_cnt[1] - base_nl), 2);
        check("e_done_count", 32'(fd_cnt[1] - base_fd), 1);
        check("e_idle_vec", 32'(outs(1)), 32'(25'h0800002));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
